// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and state encodings for the iterative RV32M multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - execute-stage RV32M unit: shift-add multiply, restoring divide, one bit per cycle
module execute_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);
    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              sa_q, sa_d;
    logic [XLEN-1:0]   res_q, res_d;

    muldiv_op_t      op_in;
    logic            sa_in, sb_in, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    assign op_in    = muldiv_op_t'(MulDivOpE);
    assign sa_in    = (op_in inside {MULH, MULHSU, DIV, REM}) && SrcAE[XLEN-1];
    assign sb_in    = (op_in inside {MULH, DIV, REM}) && SrcBE[XLEN-1];
    assign abs_a    = sa_in ? (~SrcAE + 1'b1) : SrcAE;
    assign abs_b    = sb_in ? (~SrcBE + 1'b1) : SrcBE;
    assign div_zero = MulDivOpE[2] && (SrcBE == '0);
    assign div_ovf  = (op_in inside {DIV, REM}) && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (&SrcBE);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = MulDivOpE[1] ? SrcAE : '1;
        else if (!MulDivOpE[1])
            special_res = SrcAE;
    end

    // Multiply keeps the multiplier in the low half and shifts right; divide keeps the dividend there and shifts left.
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0] step_acc, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_trial = div_shift - {1'b0, b_q};

    always_comb begin
        if (!op_q[2])
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        else if (!div_trial[XLEN])
            step_acc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            step_acc = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    assign prod = neg_q ? (~step_acc + 1'b1) : step_acc;
    assign quo  = neg_q ? (~step_acc[XLEN-1:0] + 1'b1) : step_acc[XLEN-1:0];
    assign rem  = sa_q ? (~step_acc[2*XLEN-1:XLEN] + 1'b1) : step_acc[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            MUL:                 final_res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: final_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           final_res = quo;
            default:             final_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (StartE && !FlushE) begin
                    op_d  = op_in;
                    b_d   = abs_b;
                    acc_d = {{XLEN{1'b0}}, abs_a};
                    neg_d = sa_in ^ sb_in;
                    sa_d  = sa_in;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        state_d = DONE;
                        res_d   = special_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (FlushE) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = DONE;
                        res_d   = final_res;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= MUL;
            cnt_q   <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            res_q   <= res_d;
        end
    end

    assign BusyE   = ((state_q == IDLE) && StartE && !FlushE) || ((state_q == CALC) && !FlushE);
    assign DoneE   = (state_q == DONE);
    assign ResultE = res_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb/tb_execute_muldiv_unit.sv - directed-vector bench for execute_muldiv_unit
module tb_execute_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StartE;
    logic [2:0]  MulDivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultE;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StartE    (StartE),
        .MulDivOpE (MulDivOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .BusyE     (BusyE),
        .DoneE     (DoneE),
        .ResultE   (ResultE)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op in the current (IDLE) cycle and returns in its DoneE cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic hold,
                          input logic [31:0] exp_res, input int exp_cyc);
        int cyc  = -1;
        int busy = 0;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        StartE    = 1'b1;
        #1;
        for (int n = 0; n <= 60 && cyc < 0; n++) begin
            if (n > 0) begin
                tick();
                if (!hold) StartE = 1'b0;
                #1;
            end
            if (DoneE) begin
                cyc = n;
                check_eq({tag, "_busy_in_done"}, 32'(BusyE), 32'd0);
            end else if (BusyE) begin
                busy++;
            end
        end
        check_eq({tag, "_result"}, ResultE, exp_res);
        check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_busy_cycles"}, 32'(busy), 32'(exp_cyc));
    endtask

    task automatic op_then_idle(input string tag, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
        run_op(tag, op, a, b, 1'b0, exp_res, exp_cyc);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        StartE    = 1'b0;
        FlushE    = 1'b0;
        MulDivOpE = 3'b000;
        SrcAE     = '0;
        SrcBE     = '0;
        tick();
        tick();
        check_eq("rst_done", 32'(DoneE), 32'd0);
        check_eq("rst_result", ResultE, 32'd0);
        check_eq("rst_busy_idle", 32'(BusyE), 32'd0);
        StartE = 1'b1;
        #1;
        check_eq("rst_busy_follows_start", 32'(BusyE), 32'd1);
        StartE = 1'b0;
        rst_n  = 1'b1;
        tick();

        run_op("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 33);
        tick();
        check_eq("result_holds", ResultE, 32'hFFFF_FFEB);
        check_eq("done_one_cycle", 32'(DoneE), 32'd0);

        op_then_idle("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        op_then_idle("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        op_then_idle("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        op_then_idle("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        op_then_idle("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        op_then_idle("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
        op_then_idle("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);
        op_then_idle("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        op_then_idle("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

        op_then_idle("div_by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        op_then_idle("rem_by0", REM, 32'd5, 32'd0, 32'd5, 1);
        op_then_idle("divu_by0", DIVU, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1);
        op_then_idle("remu_by0", REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);
        op_then_idle("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        op_then_idle("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        MulDivOpE = DIV;
        SrcAE     = 32'd100;
        SrcBE     = 32'd7;
        StartE    = 1'b1;
        #1;
        check_eq("flush_busy_start", 32'(BusyE), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            StartE = 1'b0;
        end
        #1;
        check_eq("flush_busy_calc", 32'(BusyE), 32'd1);
        FlushE = 1'b1;
        #1;
        check_eq("flush_busy_same_cycle", 32'(BusyE), 32'd0);
        tick();
        FlushE = 1'b0;
        #1;
        check_eq("flush_no_done", 32'(DoneE), 32'd0);
        check_eq("flush_idle_busy", 32'(BusyE), 32'd0);
        op_then_idle("flush_then_mul", MUL, 32'd3, 32'd4, 32'd12, 33);

        // StartE stays high through DONE, as a stalled pipeline would present it.
        run_op("b2b_divu", DIVU, 32'd9, 32'd3, 1'b1, 32'd3, 33);
        tick();
        run_op("b2b_mul", MUL, 32'd5, 32'd6, 1'b0, 32'd30, 33);
        tick();

        MulDivOpE = MUL;
        SrcAE     = 32'd7;
        SrcBE     = 32'd9;
        StartE    = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            tick();
            StartE = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        check_eq("midrst_done", 32'(DoneE), 32'd0);
        check_eq("midrst_result", ResultE, 32'd0);
        check_eq("midrst_busy", 32'(BusyE), 32'd0);
        rst_n = 1'b1;
        tick();
        op_then_idle("after_rst_mul", MUL, 32'd3, 32'd4, 32'd12, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
